// File: rtl/decode_mac_pipe.sv
// Pipelined signed x unsigned multiply-accumulate with valid/ready handshake and burst accumulation.
// Define DECODE_MAC_SAT_EN for a saturating accumulator with a sticky ovf flag; otherwise it wraps and ovf stays 0.
module decode_mac_pipe #(
    parameter int din0_WIDTH = 40,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 70,
    parameter int NUM_STAGE  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int LAST = NUM_STAGE - 1;

    // Returns {saturated, sum}; the flag can only be raised in the saturating build.
    function automatic logic [dout_WIDTH:0] add_sat(input logic signed [dout_WIDTH-1:0] a,
                                                     input logic signed [dout_WIDTH-1:0] b);
        logic signed [dout_WIDTH-1:0] raw;
        raw = a + b;
`ifdef DECODE_MAC_SAT_EN
        if ((a[dout_WIDTH-1] == b[dout_WIDTH-1]) && (raw[dout_WIDTH-1] != a[dout_WIDTH-1])) begin
            if (a[dout_WIDTH-1]) begin
                add_sat = {1'b1, 1'b1, {(dout_WIDTH-1){1'b0}}};
            end else begin
                add_sat = {1'b1, 1'b0, {(dout_WIDTH-1){1'b1}}};
            end
        end else begin
            add_sat = {1'b0, raw};
        end
`else
        add_sat = {1'b0, raw};
`endif
    endfunction

    logic                         adv_s;
    logic signed [dout_WIDTH-1:0] op0_s;
    logic signed [dout_WIDTH-1:0] op1_s;
    logic signed [dout_WIDTH-1:0] prod_s;
    logic signed [dout_WIDTH-1:0] sum_s;
    logic                         sat_s;

    logic [NUM_STAGE-1:0]         vld_r;
    logic [NUM_STAGE-1:0]         en_r;
    logic [NUM_STAGE-1:0]         last_r;
    logic signed [dout_WIDTH-1:0] prod_r [NUM_STAGE];
    logic signed [dout_WIDTH-1:0] acc_r;
    logic signed [dout_WIDTH-1:0] dout_r;
    logic                         out_valid_r;
    logic                         ovf_r;

    // Operand extension, product, accumulator sum and the global advance condition.
    always_comb begin
        op0_s          = {{(dout_WIDTH-din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
        op1_s          = {{(dout_WIDTH-din1_WIDTH){1'b0}}, din1};
        prod_s         = op0_s * op1_s;
        {sat_s, sum_s} = add_sat(acc_r, prod_r[LAST]);
        adv_s          = ce & (~out_valid_r | out_ready);
    end

    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign dout      = dout_r;
    assign ovf       = ovf_r;

    // Multiplier pipeline: every stage shifts together whenever the output side can advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_r  <= '0;
            en_r   <= '0;
            last_r <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_r[i] <= '0;
            end
        end else if (adv_s) begin
            vld_r[0]  <= in_valid;
            en_r[0]   <= acc_en;
            last_r[0] <= acc_last;
            prod_r[0] <= prod_s;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_r[i]  <= vld_r[i-1];
                en_r[i]   <= en_r[i-1];
                last_r[i] <= last_r[i-1];
                prod_r[i] <= prod_r[i-1];
            end
        end
    end

    // Output stage: pass products straight through or fold them into the running burst sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            acc_r       <= '0;
            ovf_r       <= 1'b0;
        end else if (adv_s) begin
            if (vld_r[LAST]) begin
                case ({en_r[LAST], last_r[LAST]})
                    2'b10: begin
                        acc_r       <= sum_s;
                        ovf_r       <= ovf_r | sat_s;
                        out_valid_r <= 1'b0;
                    end
                    2'b11: begin
                        dout_r      <= sum_s;
                        acc_r       <= '0;
                        ovf_r       <= ovf_r | sat_s;
                        out_valid_r <= 1'b1;
                    end
                    default: begin
                        dout_r      <= prod_r[LAST];
                        out_valid_r <= 1'b1;
                    end
                endcase
            end else begin
                out_valid_r <= out_valid_r & ~out_ready;
            end
        end
    end

endmodule
